// File: rtl/mecanum_ik_seq.sv
// Mecanum-wheel inverse kinematics on sign-magnitude Q16.15 words.
// A small FSM time-shares one saturating multiplier across the WZ gain and the four wheel gains.
module mecanum_ik_seq #(
    parameter int                 N_WIDTH = 32,
    parameter int                 Q_WIDTH = 15,
    parameter logic [N_WIDTH-1:0] K_GEOM  = 32'h0000_8000,
    parameter logic [N_WIDTH-1:0] R_INV   = 32'h0000_8000
) (
    input  logic               MECANUM_IK_CLOCK_50,
    input  logic               MECANUM_IK_RESET_InLow,
    input  logic               MECANUM_IK_START_In,
    input  logic [N_WIDTH-1:0] MECANUM_IK_VX_InBus,
    input  logic [N_WIDTH-1:0] MECANUM_IK_VY_InBus,
    input  logic [N_WIDTH-1:0] MECANUM_IK_WZ_InBus,
    output logic               MECANUM_IK_BUSY_Out,
    output logic               MECANUM_IK_DONE_Out,
    output logic [N_WIDTH-1:0] MECANUM_IK_W1_OutBus,
    output logic [N_WIDTH-1:0] MECANUM_IK_W2_OutBus,
    output logic [N_WIDTH-1:0] MECANUM_IK_W3_OutBus,
    output logic [N_WIDTH-1:0] MECANUM_IK_W4_OutBus
);
    localparam int M = N_WIDTH - 1;

    typedef enum logic [3:0] {
        S_IDLE, S_MULK, S_SUMAB, S_SUMW, S_SC1, S_SC2, S_SC3, S_SC4, S_DONE
    } state_t;

    // A zero magnitude always carries a positive sign, so negative zero never propagates.
    function automatic logic [N_WIDTH-1:0] sm_norm(input logic [N_WIDTH-1:0] x);
        return (x[M-1:0] == '0) ? '0 : x;
    endfunction

    function automatic logic [N_WIDTH-1:0] sm_add(input logic [N_WIDTH-1:0] a,
                                                  input logic [N_WIDTH-1:0] b);
        logic [M:0]   sum;
        logic [M-1:0] mag;
        logic         sgn;
        sum = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
        if (a[M] == b[M]) begin
            mag = sum[M] ? {M{1'b1}} : sum[M-1:0];
            sgn = a[M];
        end else if (a[M-1:0] >= b[M-1:0]) begin
            mag = a[M-1:0] - b[M-1:0];
            sgn = a[M];
        end else begin
            mag = b[M-1:0] - a[M-1:0];
            sgn = b[M];
        end
        return sm_norm({sgn, mag});
    endfunction

    function automatic logic [N_WIDTH-1:0] sm_sub(input logic [N_WIDTH-1:0] a,
                                                  input logic [N_WIDTH-1:0] b);
        return sm_add(a, {~b[M], b[M-1:0]});
    endfunction

    state_t             r_state;
    logic               r_busy, r_done;
    logic [N_WIDTH-1:0] r_vx, r_vy, r_wz, r_kw, r_a, r_b;
    logic [N_WIDTH-1:0] r_s1, r_s2, r_s3, r_s4, r_t1, r_t2, r_t3;
    logic [N_WIDTH-1:0] r_w1, r_w2, r_w3, r_w4;

    logic [N_WIDTH-1:0] w_mul_a, w_mul_b, w_mul;
    logic [2*M-1:0]     w_prod, w_prod_sh;

    // The single multiplier: operands steered by the current state.
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_mul_a = R_INV;
        w_mul_b = r_s1;
        case (r_state)
            S_MULK:  begin w_mul_a = K_GEOM; w_mul_b = r_wz; end
            S_SC2:   w_mul_b = r_s2;
            S_SC3:   w_mul_b = r_s3;
            S_SC4:   w_mul_b = r_s4;
            default: ;
        endcase
    end

    assign w_prod    = {{M{1'b0}}, w_mul_a[M-1:0]} * {{M{1'b0}}, w_mul_b[M-1:0]};
    assign w_prod_sh = w_prod >> Q_WIDTH;
    assign w_mul     = sm_norm({w_mul_a[M] ^ w_mul_b[M],
                                (|w_prod_sh[2*M-1:M]) ? {M{1'b1}} : w_prod_sh[M-1:0]});

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge MECANUM_IK_CLOCK_50) begin
        if (!MECANUM_IK_RESET_InLow) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_vx <= '0; r_vy <= '0; r_wz <= '0; r_kw <= '0; r_a <= '0; r_b <= '0;
            r_s1 <= '0; r_s2 <= '0; r_s3 <= '0; r_s4 <= '0;
            r_t1 <= '0; r_t2 <= '0; r_t3 <= '0;
            r_w1 <= '0; r_w2 <= '0; r_w3 <= '0; r_w4 <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (MECANUM_IK_START_In) begin
                    r_vx    <= sm_norm(MECANUM_IK_VX_InBus);
                    r_vy    <= sm_norm(MECANUM_IK_VY_InBus);
                    r_wz    <= sm_norm(MECANUM_IK_WZ_InBus);
                    r_busy  <= 1'b1;
                    r_state <= S_MULK;
                end
                S_MULK: begin
                    r_kw    <= w_mul;
                    r_state <= S_SUMAB;
                end
                S_SUMAB: begin
                    r_a     <= sm_add(r_vx, r_vy);
                    r_b     <= sm_sub(r_vx, r_vy);
                    r_state <= S_SUMW;
                end
                S_SUMW: begin
                    r_s1    <= sm_sub(r_b, r_kw);
                    r_s2    <= sm_add(r_a, r_kw);
                    r_s3    <= sm_sub(r_a, r_kw);
                    r_s4    <= sm_add(r_b, r_kw);
                    r_state <= S_SC1;
                end
                S_SC1: begin r_t1 <= w_mul; r_state <= S_SC2; end
                S_SC2: begin r_t2 <= w_mul; r_state <= S_SC3; end
                S_SC3: begin r_t3 <= w_mul; r_state <= S_SC4; end
                S_SC4: begin
                    // All four wheels update together, so outputs never show a partial set.
                    r_w1    <= r_t1;
                    r_w2    <= r_t2;
                    r_w3    <= r_t3;
                    r_w4    <= w_mul;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign MECANUM_IK_BUSY_Out  = r_busy;
    assign MECANUM_IK_DONE_Out  = r_done;
    assign MECANUM_IK_W1_OutBus = r_w1;
    assign MECANUM_IK_W2_OutBus = r_w2;
    assign MECANUM_IK_W3_OutBus = r_w3;
    assign MECANUM_IK_W4_OutBus = r_w4;
endmodule

// File: tb/tb_mecanum_ik_seq.sv
// Directed bench for mecanum_ik_seq: unit-gain instance plus a K_GEOM=0.5 instance,
// with hand-computed wheel values, latency, handshake and reset cases.
module tb_mecanum_ik_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] vx = '0, vy = '0, wz = '0;
    logic        busy0, done0, busy1, done1;
    logic [31:0] w01, w02, w03, w04, w11, w12, w13, w14;

    int checks = 0;
    int failures = 0;
    int lat, busy_cyc, done_cnt;

    always #5 clk = ~clk;

    mecanum_ik_seq dut0 (
        .MECANUM_IK_CLOCK_50(clk), .MECANUM_IK_RESET_InLow(rst_n),
        .MECANUM_IK_START_In(start0),
        .MECANUM_IK_VX_InBus(vx), .MECANUM_IK_VY_InBus(vy), .MECANUM_IK_WZ_InBus(wz),
        .MECANUM_IK_BUSY_Out(busy0), .MECANUM_IK_DONE_Out(done0),
        .MECANUM_IK_W1_OutBus(w01), .MECANUM_IK_W2_OutBus(w02),
        .MECANUM_IK_W3_OutBus(w03), .MECANUM_IK_W4_OutBus(w04)
    );

    mecanum_ik_seq #(.K_GEOM(32'h0000_4000)) dut1 (
        .MECANUM_IK_CLOCK_50(clk), .MECANUM_IK_RESET_InLow(rst_n),
        .MECANUM_IK_START_In(start1),
        .MECANUM_IK_VX_InBus(vx), .MECANUM_IK_VY_InBus(vy), .MECANUM_IK_WZ_InBus(wz),
        .MECANUM_IK_BUSY_Out(busy1), .MECANUM_IK_DONE_Out(done1),
        .MECANUM_IK_W1_OutBus(w11), .MECANUM_IK_W2_OutBus(w12),
        .MECANUM_IK_W3_OutBus(w13), .MECANUM_IK_W4_OutBus(w14)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input bit sel, input string tag, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
        check({tag, ".w1"}, sel ? w11 : w01, e1);
        check({tag, ".w2"}, sel ? w12 : w02, e2);
        check({tag, ".w3"}, sel ? w13 : w03, e3);
        check({tag, ".w4"}, sel ? w14 : w04, e4);
    endtask

    // One request; j counts negedges after the START-sampling edge. Optional extra START
    // pulses at p1/p2 (with different inputs) and a reset sampled at edge n+rst_at.
    task automatic run(input bit sel, input logic [31:0] ivx, input logic [31:0] ivy,
                       input logic [31:0] iwz, input int p1, input int p2, input int rst_at);
        @(negedge clk);
        vx = ivx; vy = ivy; wz = iwz;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        lat = -1; busy_cyc = 0; done_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            if (sel ? busy1 : busy0) busy_cyc++;
            if (sel ? done1 : done0) begin
                done_cnt++;
                if (lat < 0) lat = j;
            end
            if (j == 0) begin
                vx = 32'h1234_5678; vy = 32'h8765_4321; wz = 32'h0F0F_0F0F;
            end
            if (j == p1 || j == p2) begin
                vx = 32'h0; vy = 32'h0000_8000; wz = 32'h0001_0000;
                if (sel) start1 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0; start1 = 1'b0;
            end
            rst_n = (j == rst_at - 1) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        start0 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.busy", {31'b0, busy0}, 32'd0);
        check("rst.done", {31'b0, done0}, 32'd0);
        check_w(1'b0, "rst", 32'h0, 32'h0, 32'h0, 32'h0);

        run(1'b0, 32'h0000_8000, 32'h0, 32'h0, -1, -1, -1);
        check("vx1.latency", lat, 32'd7);
        check("vx1.busy_cycles", busy_cyc, 32'd8);
        check("vx1.done_count", done_cnt, 32'd1);
        check_w(1'b0, "vx1", 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);

        run(1'b0, 32'h0, 32'h0000_8000, 32'h0, -1, -1, -1);
        check_w(1'b0, "vy1", 32'h8000_8000, 32'h0000_8000, 32'h0000_8000, 32'h8000_8000);

        run(1'b1, 32'h0, 32'h0, 32'h0001_0000, -1, -1, -1);
        check("wz2.latency", lat, 32'd7);
        check_w(1'b1, "wz2", 32'h8000_8000, 32'h0000_8000, 32'h8000_8000, 32'h0000_8000);

        // 3 LSB * 0.5 truncates to 1 LSB
        run(1'b1, 32'h0, 32'h0, 32'h0000_0003, -1, -1, -1);
        check_w(1'b1, "trunc", 32'h8000_0001, 32'h0000_0001, 32'h8000_0001, 32'h0000_0001);

        run(1'b0, 32'h0000_8000, 32'h0000_8000, 32'h0, -1, -1, -1);
        check_w(1'b0, "vxvy", 32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0);

        run(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, -1, -1, -1);
        check_w(1'b0, "sat", 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0);

        // VX=3, VY=-1, WZ=-5: a=2, b=4, kw=-5
        run(1'b0, 32'h0001_8000, 32'h8000_8000, 32'h8002_8000, -1, -1, -1);
        check_w(1'b0, "mixed", 32'h0004_8000, 32'h8001_8000, 32'h0003_8000, 32'h8000_8000);

        run(1'b0, 32'h0000_8000, 32'h0, 32'h0, 3, 7, -1);
        check("restart.done_count", done_cnt, 32'd1);
        check_w(1'b0, "restart", 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);

        run(1'b0, 32'h0001_8000, 32'h8000_8000, 32'h8002_8000, -1, -1, 4);
        check("midrst.done_count", done_cnt, 32'd0);
        check("midrst.busy", {31'b0, busy0}, 32'd0);
        check_w(1'b0, "midrst", 32'h0, 32'h0, 32'h0, 32'h0);

        @(negedge clk);
        rst_n = 1'b0; start0 = 1'b1; vx = 32'h0000_8000; vy = '0; wz = '0;
        @(negedge clk);
        rst_n = 1'b1; start0 = 1'b0;
        check("rststart.busy", {31'b0, busy0}, 32'd0);
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done0) done_cnt++;
        end
        check("rststart.done_count", done_cnt, 32'd0);

        run(1'b0, 32'h0000_8000, 32'h0, 32'h0, -1, -1, -1);
        check("fresh.latency", lat, 32'd7);
        check_w(1'b0, "fresh", 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);

        run(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, -1, -1, -1);
        check_w(1'b0, "negzero", 32'h0, 32'h0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mecanum_ik_seq.md
Name: mecanum_ik_seq

Overview:
- Sequential inverse-kinematics stage directly downstream of the error-to-velocity controller.
- Takes body velocity commands VX, VY, WZ in 32-bit sign-magnitude Q16.15 and produces four mecanum wheel speed commands in the same format for the wheel PWM/PID stages.
- Uses one shared multiplier under an FSM, with a start/done handshake.

Parameters:
- N_WIDTH, 32, word width; bit N_WIDTH-1 is the sign, the rest is magnitude.
- Q_WIDTH, 15, fractional bits.
- K_GEOM, 32'h0000_8000 (1.0), (Lx+Ly) times unit-conversion gain applied to WZ; positive sign-magnitude.
- R_INV, 32'h0000_8000 (1.0), 1/wheel-radius gain applied to each wheel sum; positive sign-magnitude.

Ports:
- MECANUM_IK_CLOCK_50  in  1  system clock; all logic on its rising edge.
- MECANUM_IK_RESET_InLow  in  1  reset, synchronous, active-low.
- MECANUM_IK_START_In  in  1  request pulse; sampled only in IDLE.
- MECANUM_IK_VX_InBus  in  N_WIDTH  forward velocity.
- MECANUM_IK_VY_InBus  in  N_WIDTH  lateral velocity.
- MECANUM_IK_WZ_InBus  in  N_WIDTH  angular velocity.
- MECANUM_IK_BUSY_Out  out  1  high in every state except IDLE.
- MECANUM_IK_DONE_Out  out  1  one-cycle pulse; all four wheel outputs are valid from this cycle on.
- MECANUM_IK_W1_OutBus  out  N_WIDTH  wheel 1 (front-left).
- MECANUM_IK_W2_OutBus  out  N_WIDTH  wheel 2 (front-right).
- MECANUM_IK_W3_OutBus  out  N_WIDTH  wheel 3 (rear-left).
- MECANUM_IK_W4_OutBus  out  N_WIDTH  wheel 4 (rear-right).

Behaviour:
- Reset:
  - Applies when RESET_InLow=0 at a clock edge, in any state, including mid-computation.
  - FSM goes to IDLE; BUSY=0, DONE=0; W1..W4=0; all internal registers cleared.
  - Any computation in flight is discarded and no DONE is produced.
- Number format:
  - Sign-magnitude Q16.15.
  - Inputs of 0x8000_0000 (negative zero) are treated as zero.
  - No result, internal or output, ever carries negative zero: zero magnitude forces sign 0.
- Add/sub:
  - Subtraction flips the sign of the second operand.
  - Equal signs: add magnitudes.
  - Different signs: larger magnitude minus smaller; result takes the sign of the larger.
  - Magnitude overflow beyond 31 bits saturates to 0x7FFF_FFFF (keeping the sign).
- Multiply:
  - Sign = XOR of operand signs.
  - Magnitude = (magA*magB) >> Q_WIDTH, truncated.
  - Result above 31 bits saturates to all-ones magnitude.
  - Exactly one multiplier instance is used.
- FSM and timing (edge n = the edge that samples START=1 in IDLE):
  - IDLE: waits for START. At edge n, VX, VY, WZ are latched; go to MULK.
  - MULK: kw = K_GEOM*WZ, registered at edge n+1; go to SUMAB.
  - SUMAB: a = VX+VY and b = VX−VY, registered at edge n+2; go to SUMW.
  - SUMW: s1=b−kw, s2=a+kw, s3=a−kw, s4=b+kw, registered at edge n+3; go to SC1.
  - SC1..SC4: one multiply per state, t_i = R_INV*s_i; t1 at edge n+4 through t4 at edge n+7. SC4 goes to DONE.
  - DONE: W1..W4 <= t1..t4 together at edge n+7. DONE_Out=1 for exactly the cycle after edge n+7. Next edge returns to IDLE.
  - Latency: 7 clocks from the START-sampling edge to the DONE-visible cycle.
  - Throughput: one request per 9 clocks at most.
- Handshake:
  - START while BUSY=1, including in the DONE state, is ignored; it is not queued.
  - Input buses may change freely after edge n.
  - W1..W4 hold their last values until the next DONE; they never show partial results.
- Reset asserted in the same cycle as START: reset wins.

Test Plan:
- Reset, then VX=0x0000_8000, VY=0, WZ=0, START pulse -> DONE exactly 7 cycles after the start edge; W1..W4 all 0x0000_8000; BUSY high for 8 cycles.
- VX=0, VY=0x0000_8000, WZ=0 -> W1=0x8000_8000, W2=0x0000_8000, W3=0x0000_8000, W4=0x8000_8000.
- K_GEOM=0x0000_4000, WZ=0x0001_0000, VX=VY=0 -> kw=1.0; W1=0x8000_8000, W2=0x0000_8000, W3=0x8000_8000, W4=0x0000_8000.
- VX=VY=0x0000_8000, WZ=0 -> W1=W4=0x0000_0000 (not 0x8000_0000); W2=W3=0x0001_0000. Separately, VX=VY=0x7FFF_FFFF -> W2=W3=0x7FFF_FFFF (saturated).
- Reset and START edge cases:
  - Second START pulse during BUSY -> ignored: exactly one DONE, outputs from the first inputs only.
  - Reset asserted at edge n+4 -> no DONE; outputs 0; a fresh START then completes normally.
- Negative zero: VX=0x8000_0000, VY=0x8000_0000, WZ=0 -> all outputs 0x0000_0000.
